// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs, ALU controls, states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

    // Primary opcodes (IR[31:26]) of the supported subset
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation select seen by the datapath
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Coarse ALU request from the sequencer; refined by the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Sequencer states
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } ctrl_state_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the sequencer's aluop plus the R-type funct field to an ALU control code.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module mc_aludec
    import mips_pkg::*;
(
    input  aluop_t      aluop_i,
    input  logic [5:0]  funct_i,
    output logic [2:0]  alucontrol_o
);

    // Unknown functs fall back to add rather than being flagged
    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alucontrol_o = ALU_ADD;
                    FN_SUB:  alucontrol_o = ALU_SUB;
                    FN_AND:  alucontrol_o = ALU_AND;
                    FN_OR:   alucontrol_o = ALU_OR;
                    FN_SLT:  alucontrol_o = ALU_SLT;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multicycle MIPS core, with retired and illegal-opcode counters.
// Latency: 3-5 cycles per instruction with zero-wait memory; each memory wait cycle adds one.
// Backpressure: FETCH, MEMRD and MEMWR hold (request stable, no write enables) until mem_ready.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int ILLEGAL_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [2:0]           alucontrol,
    output logic                 pcen,
    output logic [CNT_W-1:0]     retired,
    output logic [ILLEGAL_W-1:0] illegal_cnt,
    output logic                 illegal_op
);

    ctrl_state_t            state_q, state_d;
    logic [CNT_W-1:0]       retired_q;
    logic [ILLEGAL_W-1:0]   illegal_q;
    aluop_t                 aluop;
    logic                   pcwrite;
    logic                   branch;
    logic                   retire;
    logic                   illegal_dec;
    logic [2:0]             alucontrol_raw;

    mc_aludec u_aludec (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .alucontrol_o (alucontrol_raw)
    );

    // While reset is asserted the datapath must see no request or write enable
    assign alucontrol  = reset ? 3'b000 : alucontrol_raw;
    assign retired     = retired_q;
    assign illegal_cnt = illegal_q;

    // Next-state and per-state control decode; everything defaults to idle
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = ALUOP_ADD;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        retire      = 1'b0;
        illegal_dec = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 computed every cycle; only committed when the fetch lands
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_dec = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        pcen       = pcwrite | (branch & zero);
        illegal_op = illegal_dec;

        if (reset) begin
            mem_req    = 1'b0;
            iord       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            pcen       = 1'b0;
            illegal_op = 1'b0;
        end
    end

    // State register plus wrapping retire counter and saturating illegal counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (illegal_dec && (illegal_q != {ILLEGAL_W{1'b1}})) begin
                illegal_q <= illegal_q + ILLEGAL_W'(1);
            end
        end
    end

endmodule
